// File: rtl/prog_loader.sv
// Framed byte-stream loader writing program RAM and holding the CPU during a load.
// Define PROG_LOADER_ECHO_EN to echo every accepted byte plus an ACK/NAK on tx.
module prog_loader #(
  parameter int          ADDR_W  = 12,
  parameter int          TIMEOUT = 100000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              busy,
  output logic              error,
  output logic              tx_valid,
  output logic [7:0]        tx_data
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LHI  = 3'd1;
  localparam logic [2:0] S_LLO  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  logic [2:0]        r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_idx;
  logic [7:0]        r_sum;
  logic [TW-1:0]     r_tmo;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_hold;
  logic              r_restart;
  logic              r_err;

  logic [15:0] w_idx_nx;
  logic        w_expire;
  logic        w_csum_ok;

  assign w_idx_nx  = r_idx + 16'd1;
  assign w_csum_ok = (rx_data == r_sum);
  // rx_valid on the expiry cycle wins over the timeout
  assign w_expire  = (r_state != S_IDLE) && !rx_valid &&
                     (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_tmo     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_hold    <= 1'b0;
      r_restart <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_restart <= 1'b0;
      if (rx_valid) begin
        r_tmo <= '0;
        unique case (r_state)
          S_IDLE: begin
            if (rx_data == SYNC) begin
              r_state <= S_LHI;
              r_hold  <= 1'b1;
              r_err   <= 1'b0;
              r_sum   <= '0;
              r_idx   <= '0;
            end
          end
          S_LHI: begin
            r_len[15:8] <= rx_data;
            r_state     <= S_LLO;
          end
          S_LLO: begin
            r_len[7:0] <= rx_data;
            if ({r_len[15:8], rx_data} == 16'd0)
              r_state <= S_CSUM;
            else
              r_state <= S_DATA;
          end
          S_DATA: begin
            r_we    <= 1'b1;
            r_addr  <= r_idx[ADDR_W-1:0];
            r_wdata <= rx_data;
            r_sum   <= r_sum + rx_data;
            r_idx   <= w_idx_nx;
            if (w_idx_nx == r_len)
              r_state <= S_CSUM;
          end
          S_CSUM: begin
            if (w_csum_ok) begin
              r_hold    <= 1'b0;
              r_restart <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (w_expire) begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
          r_tmo   <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end
    end
  end

  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_data    = r_wdata;
  assign cpu_hold    = r_hold;
  assign cpu_restart = r_restart;
  assign error       = r_err;
  assign busy        = (r_state != S_IDLE);

`ifdef PROG_LOADER_ECHO_EN
  logic       r_txv;
  logic [7:0] r_txd;
  logic       r_pend;
  logic [7:0] r_pcode;
  logic       w_fin;
  logic       w_ack;

  assign w_ack = rx_valid && (r_state == S_CSUM);
  assign w_fin = w_ack || w_expire;

  // ACK/NAK waits in r_pend until a cycle with no byte echo
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txv   <= 1'b0;
      r_txd   <= '0;
      r_pend  <= 1'b0;
      r_pcode <= '0;
    end else begin
      r_txv <= 1'b0;
      if (rx_valid) begin
        r_txv <= 1'b1;
        r_txd <= rx_data;
      end else if (r_pend) begin
        r_txv  <= 1'b1;
        r_txd  <= r_pcode;
        r_pend <= 1'b0;
      end
      if (w_fin) begin
        r_pend  <= 1'b1;
        r_pcode <= (w_ack && w_csum_ok) ? 8'h06 : 8'h15;
      end
    end
  end

  assign tx_valid = r_txv;
  assign tx_data  = r_txd;
`else
  assign tx_valid = 1'b0;
  assign tx_data  = 8'h00;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (ADDR_W=2, short timeout).
// Echo checks are compiled in when PROG_LOADER_ECHO_EN is defined.
module tb_prog_loader;

  localparam int AW = 2;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          cpu_hold;
  logic          cpu_restart;
  logic          busy;
  logic          error;
  logic          tx_valid;
  logic [7:0]    tx_data;

  prog_loader #(
    .ADDR_W (AW),
    .TIMEOUT(TO),
    .SYNC   (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .cpu_hold   (cpu_hold),
    .cpu_restart(cpu_restart),
    .busy       (busy),
    .error      (error),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] wa [512];
  logic [7:0] wd [512];
  int         wc [512];
  int         nw  = 0;
  int         nrs = 0;
  logic [7:0] ta [512];
  int         ntx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we && nw < 512) begin
      wa[nw] = 8'(mem_addr);
      wd[nw] = mem_data;
      wc[nw] = cyc;
      nw++;
    end
    if (cpu_restart) nrs++;
    if (tx_valid && ntx < 512) begin
      ta[ntx] = tx_data;
      ntx++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input int i,
                      input logic [7:0] a, input logic [7:0] d);
    chk({tag, ".addr"}, 32'(wa[i]), 32'(a));
    chk({tag, ".data"}, 32'(wd[i]), 32'(d));
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int bw, br, bt;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    chk("rst.we",      32'(mem_we), 0);
    chk("rst.addr",    32'(mem_addr), 0);
    chk("rst.data",    32'(mem_data), 0);
    chk("rst.hold",    32'(cpu_hold), 0);
    chk("rst.restart", 32'(cpu_restart), 0);
    chk("rst.busy",    32'(busy), 0);
    chk("rst.error",   32'(error), 0);
    chk("rst.txv",     32'(tx_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // good load
    bw = nw; br = nrs; bt = ntx;
    send(8'hA5);
    chk("good.hold_on", 32'(cpu_hold), 1);
    chk("good.busy_on", 32'(busy), 1);
    send(8'h00); send(8'h03);
    send(8'h31); send(8'h20); send(8'hFF);
    chk("good.hold_mid", 32'(cpu_hold), 1);
    send(8'h50);
    chk("good.hold_off", 32'(cpu_hold), 0);
    chk("good.restart",  32'(cpu_restart), 1);
    chk("good.error",    32'(error), 0);
    chk("good.busy",     32'(busy), 0);
    idle(3);
    chk("good.restart_n", 32'(nrs - br), 1);
    chk("good.nwrites",   32'(nw - bw), 3);
    chkw("good.w0", bw,     8'h00, 8'h31);
    chkw("good.w1", bw + 1, 8'h01, 8'h20);
    chkw("good.w2", bw + 2, 8'h02, 8'hFF);
`ifdef PROG_LOADER_ECHO_EN
    chk("good.ntx",  32'(ntx - bt), 8);
    chk("good.tx0",  32'(ta[bt]), 32'h A5);
    chk("good.tx6",  32'(ta[bt + 6]), 32'h50);
    chk("good.ack",  32'(ta[bt + 7]), 32'h06);
`endif

    // bad checksum
    bw = nw; br = nrs; bt = ntx;
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h10); send(8'h20); send(8'h31);
    idle(3);
    chk("bad.nwrites", 32'(nw - bw), 2);
    chkw("bad.w0", bw,     8'h00, 8'h10);
    chkw("bad.w1", bw + 1, 8'h01, 8'h20);
    chk("bad.error",   32'(error), 1);
    chk("bad.hold",    32'(cpu_hold), 1);
    chk("bad.busy",    32'(busy), 0);
    chk("bad.restart", 32'(nrs - br), 0);
`ifdef PROG_LOADER_ECHO_EN
    chk("bad.ntx", 32'(ntx - bt), 7);
    chk("bad.tx5", 32'(ta[bt + 5]), 32'h31);
    chk("bad.nak", 32'(ta[bt + 6]), 32'h15);
`endif

    // good frame after error, SYNC value as payload
    bw = nw; br = nrs; bt = ntx;
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hA5); send(8'hA5);
    idle(3);
    chk("rec.nwrites", 32'(nw - bw), 1);
    chkw("rec.w0", bw, 8'h00, 8'hA5);
    chk("rec.error",   32'(error), 0);
    chk("rec.hold",    32'(cpu_hold), 0);
    chk("rec.restart", 32'(nrs - br), 1);
`ifdef PROG_LOADER_ECHO_EN
    chk("rec.ntx", 32'(ntx - bt), 6);
    chk("rec.ack", 32'(ta[bt + 5]), 32'h06);
`endif

    // zero length with leading junk
    bw = nw; br = nrs; bt = ntx;
    send(8'h00); send(8'h7E);
    chk("zero.junk_busy", 32'(busy), 0);
    chk("zero.junk_hold", 32'(cpu_hold), 0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    idle(3);
    chk("zero.nwrites", 32'(nw - bw), 0);
    chk("zero.restart", 32'(nrs - br), 1);
    chk("zero.error",   32'(error), 0);
    chk("zero.busy",    32'(busy), 0);
`ifdef PROG_LOADER_ECHO_EN
    chk("zero.ntx",  32'(ntx - bt), 7);
    chk("zero.tx0",  32'(ta[bt]), 32'h00);
    chk("zero.tx1",  32'(ta[bt + 1]), 32'h7E);
    chk("zero.ack",  32'(ta[bt + 6]), 32'h06);
`endif

    // timeout mid-DATA
    bw = nw; br = nrs; bt = ntx;
    send(8'hA5); send(8'h00); send(8'h04); send(8'h11);
    idle(TO - 1);
    chk("tmo.busy_pre",  32'(busy), 1);
    chk("tmo.error_pre", 32'(error), 0);
    idle(1);
    chk("tmo.busy",  32'(busy), 0);
    chk("tmo.error", 32'(error), 1);
    chk("tmo.hold",  32'(cpu_hold), 1);
    idle(3);
    chk("tmo.nwrites", 32'(nw - bw), 1);
    chk("tmo.restart", 32'(nrs - br), 0);
`ifdef PROG_LOADER_ECHO_EN
    chk("tmo.ntx", 32'(ntx - bt), 5);
    chk("tmo.nak", 32'(ta[bt + 4]), 32'h15);
`endif

    // reset mid-DATA
    send(8'hA5); send(8'h00); send(8'h03); send(8'hAA);
    chk("rmid.we_pre", 32'(mem_we), 1);
    chk("rmid.busy_pre", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("rmid.we",      32'(mem_we), 0);
    chk("rmid.addr",    32'(mem_addr), 0);
    chk("rmid.data",    32'(mem_data), 0);
    chk("rmid.hold",    32'(cpu_hold), 0);
    chk("rmid.restart", 32'(cpu_restart), 0);
    chk("rmid.busy",    32'(busy), 0);
    chk("rmid.error",   32'(error), 0);
    chk("rmid.txv",     32'(tx_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // burst with address wrap
    bw = nw; br = nrs; bt = ntx;
    send(8'hA5); send(8'h00); send(8'h05);
    send(8'h01); send(8'h02); send(8'h03);
    send(8'h04); send(8'h05); send(8'h0F);
    idle(3);
    chk("wrap.nwrites", 32'(nw - bw), 5);
    chkw("wrap.w0", bw,     8'h00, 8'h01);
    chkw("wrap.w1", bw + 1, 8'h01, 8'h02);
    chkw("wrap.w2", bw + 2, 8'h02, 8'h03);
    chkw("wrap.w3", bw + 3, 8'h03, 8'h04);
    chkw("wrap.w4", bw + 4, 8'h00, 8'h05);
    for (int k = 0; k < 4; k++)
      chk("wrap.consec", 32'(wc[bw + k + 1] - wc[bw + k]), 1);
    chk("wrap.restart", 32'(nrs - br), 1);
    chk("wrap.error",   32'(error), 0);
    chk("wrap.hold",    32'(cpu_hold), 0);
`ifdef PROG_LOADER_ECHO_EN
    chk("wrap.ntx", 32'(ntx - bt), 10);
    chk("wrap.ack", 32'(ta[bt + 9]), 32'h06);
`else
    chk("noecho.ntx", 32'(ntx), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
